// File: rtl/uart_transmit_if.sv
// uart_transmit_if: byte push handshake plus the serial line and status outputs of uart_transmit
interface uart_transmit_if;
    logic [7:0] data_byte_in;
    logic       trigger_in;
    logic       ready_out;
    logic       busy_out;
    logic       tx_wire_out;
    modport master (output data_byte_in, trigger_in, input ready_out, busy_out, tx_wire_out);
    modport slave (input data_byte_in, trigger_in, output ready_out, busy_out, tx_wire_out);
endinterface

// File: rtl/uart_transmit.sv
// uart_transmit: 8N1 UART transmitter fed by a small byte FIFO
// Queued bytes leave back-to-back; the line is registered and idles high.
module uart_transmit #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 115_200,
    parameter int FIFO_DEPTH       = 4
) (
    input logic            clk_in,
    input logic            rst_in,
    uart_transmit_if.slave bus
);
    localparam int PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int BW     = $clog2(PERIOD) + 1;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t         state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic           tx_q, tx_d, busy_q;
    logic           push, pop, bit_end;
    assign bus.ready_out   = count_q != CW'(FIFO_DEPTH);
    assign bus.busy_out    = busy_q;
    assign bus.tx_wire_out = tx_q;
    assign push            = bus.trigger_in && bus.ready_out;
    assign bit_end         = baud_q == BW'(PERIOD - 1);
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE:  pop = count_q != '0;
            START: state_d = bit_end ? DATA : START;
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? STOP : DATA;
            end
            default: if (bit_end) begin
                pop     = count_q != '0;
                state_d = IDLE;
            end
        endcase
        // a pop always starts a new frame, whether from IDLE or straight out of STOP
        if (pop) begin
            shift_d = mem_q[rd_q];
            bit_d   = '0;
            state_d = START;
        end
        baud_d  = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
        tx_d    = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
        count_d = count_q + CW'(push) - CW'(pop);
        rd_d    = rd_q + PW'(pop);
        wr_d    = wr_q + PW'(push);
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            tx_q    <= tx_d;
            busy_q  <= state_q != IDLE || count_q != '0;
        end
    end
    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_q] <= bus.data_byte_in;
    end
endmodule

// File: tb/tb_uart_transmit.sv
// tb_uart_transmit: randomized and directed checks of uart_transmit against a frame-timeline model
// A line decoder in the bench recovers bytes for end-to-end ordering checks.
module tb_uart_transmit;
    localparam int P     = 10;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    uart_transmit_if bus ();
    uart_transmit #(.INPUT_CLOCK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk), .rst_in(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int frame_bit(input int b, input int idx);
        return idx == 0 ? 0 : idx == 9 ? 1 : (b >> (idx - 1)) & 1;
    endfunction
    // model: FIFO as a queue, each frame described by the edge it was popped on
    int          mq[$];
    bit          m_act = 0;
    int          m_start = 0;
    int          m_byte = 0;
    int          cyc = 0;
    int          m_n, e_tx = 1, e_busy = 0;
    bit          m_pre, m_acc;
    always begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            mq.delete();
            m_act  = 0;
            e_tx   = 1;
            e_busy = 0;
        end else begin
            m_n    = mq.size();
            m_pre  = m_act;
            m_acc  = bus.trigger_in && m_n < DEPTH;
            e_busy = (m_pre || m_n != 0) ? 1 : 0;
            e_tx   = m_pre ? frame_bit(m_byte, (cyc - 1 - m_start) / P) : 1;
            if (m_pre && cyc == m_start + 10 * P) m_act = 0;
            if (!m_act && m_n != 0) begin
                m_byte  = mq.pop_front();
                m_act   = 1;
                m_start = cyc;
            end
            if (m_acc) mq.push_back(int'(bus.data_byte_in));
        end
        #1;
        chk("tx_line", bus.tx_wire_out, e_tx);
        chk("busy", bus.busy_out, e_busy);
        chk("ready", bus.ready_out, mq.size() < DEPTH ? 1 : 0);
    end
    int         rxq[$];
    bit         r_on = 0;
    int         r_cnt = 0;
    logic [7:0] r_sh = '0;
    always begin
        @(posedge clk);
        if (rst) r_on = 0;
        else if (!r_on) begin
            if (bus.tx_wire_out == 1'b0) begin
                r_on  = 1;
                r_cnt = 0;
            end
        end else begin
            r_cnt++;
            if (r_cnt % P == P / 2 && r_cnt / P >= 1 && r_cnt / P <= 8) r_sh[r_cnt/P-1] = bus.tx_wire_out;
            if (r_cnt == 9 * P + P / 2) begin
                chk("rx_stop_bit", bus.tx_wire_out, 1);
                rxq.push_back(int'(r_sh));
                r_on = 0;
            end
        end
    end
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [7:0] b);
        @(negedge clk);
        bus.trigger_in   = 1'b1;
        bus.data_byte_in = b;
        @(negedge clk);
        bus.trigger_in = 1'b0;
    endtask
    task automatic expect_rx(input int b);
        chk("rx_byte", rxq.size() != 0 ? rxq.pop_front() : -1, b);
    endtask
    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        repeat (3) @(negedge clk);
        while (bus.busy_out && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("idle_reached", bus.busy_out, 0);
        repeat (2) @(negedge clk);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    int exp_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    initial begin
        bus.trigger_in   = 1'b0;
        bus.data_byte_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_tx", bus.tx_wire_out, 1);
        chk("reset_busy", bus.busy_out, 0);
        chk("reset_ready", bus.ready_out, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        push(8'hA5);
        step(2);
        for (int i = 0; i < 10; i++) begin
            chk("a5_frame_bit", bus.tx_wire_out, exp_a5[i]);
            if (i < 9) step(10);
        end
        step(9);
        chk("a5_busy_last", bus.busy_out, 1);
        step(1);
        chk("a5_busy_drop", bus.busy_out, 0);
        chk("a5_line_idle", bus.tx_wire_out, 1);
        expect_rx(8'hA5);
        @(negedge clk);
        bus.trigger_in   = 1'b1;
        bus.data_byte_in = 8'h00;
        @(negedge clk);
        bus.data_byte_in = 8'hFF;
        @(negedge clk);
        bus.trigger_in = 1'b0;
        step(100);
        chk("b2b_stop_of_00", bus.tx_wire_out, 1);
        step(1);
        chk("b2b_start_of_ff", bus.tx_wire_out, 0);
        wait_idle(400);
        expect_rx(8'h00);
        expect_rx(8'hFF);
        @(negedge clk);
        bus.trigger_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.data_byte_in = i == 5 ? 8'h99 : 8'h11 + 8'(i);
            if (i == 5) chk("full_ready_before_6th", bus.ready_out, 0);
            @(negedge clk);
        end
        bus.trigger_in = 1'b0;
        chk("full_ready_after", bus.ready_out, 0);
        wait_idle(700);
        for (int i = 0; i < 5; i++) expect_rx(8'h11 + i);
        chk("dropped_byte_absent", rxq.size(), 0);
        @(negedge clk);
        bus.trigger_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.data_byte_in = i == 0 ? 8'h3C : i == 1 ? 8'hAA : 8'hBB;
            @(negedge clk);
        end
        bus.trigger_in = 1'b0;
        repeat (45) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_tx", bus.tx_wire_out, 1);
        chk("async_rst_busy", bus.busy_out, 0);
        chk("async_rst_ready", bus.ready_out, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(150);
        chk("post_rst_busy", bus.busy_out, 0);
        chk("post_rst_no_frame", rxq.size(), 0);
        @(negedge clk);
        bus.trigger_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.data_byte_in = i == 0 ? 8'h5A : 8'(i);
            @(negedge clk);
        end
        bus.trigger_in = 1'b0;
        repeat (96) @(negedge clk);
        chk("stop_end_ready", bus.ready_out, 0);
        bus.trigger_in   = 1'b1;
        bus.data_byte_in = 8'h77;
        @(negedge clk);
        bus.trigger_in = 1'b0;
        chk("stop_end_after_pop_ready", bus.ready_out, 1);
        wait_idle(700);
        expect_rx(8'h5A);
        for (int i = 1; i < 5; i++) expect_rx(i);
        chk("stop_end_rejected", rxq.size(), 0);
        for (int i = 0; i < 256; i++) begin
            int t;
            t = 0;
            @(negedge clk);
            while (!bus.ready_out && t < 400) begin
                bus.trigger_in   = 1'($urandom_range(0, 1));
                bus.data_byte_in = 8'($urandom);
                @(negedge clk);
                t++;
            end
            if (t >= 400) chk("ready_timeout", bus.ready_out, 1);
            bus.trigger_in   = 1'b1;
            bus.data_byte_in = 8'(i);
            @(negedge clk);
            bus.trigger_in = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle(800);
        for (int i = 0; i < 256; i++) expect_rx(i);
        chk("loopback_no_extra", rxq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
